gsim_sched: RTL and testbench
=============================

// Module: gsim_sched
// PURPOSE
//  Sequencer for the 16-unknown Gauss-Seidel solver (banded matrix, coefficients 20,-13,6,-1).
//  - Accepts the b vector and drives the b-buffer write port.
//  - Schedules forward row sweeps on a shared row-update datapath through a start/done handshake.
//  - Counts iterations, then streams x[0..15] out of the x register file.
//  - Sits between the top-level GSIM ports and the arithmetic datapath.
// PARAMETERS
//  N_DIM     16  number of unknowns (power of 2)
//  ITER_MAX  64  full sweeps before output (1..255)
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  in_en          in   1  b_in element valid (b data goes straight to the buffer)
//  b_we           out  1  b-buffer write enable
//  b_addr         out  4  b-buffer write address
//  dp_start       out  1  one-cycle pulse: update row dp_row
//  dp_row         out  4  row index being updated
//  dp_nbr_mask    out  6  in-range neighbours {i+3,i+2,i+1,i-1,i-2,i-3}, MSB = i+3
//  dp_done        in   1  one-cycle pulse: new x[dp_row] ready
//  dp_small       in   1  |delta x[row]| below threshold, sampled with dp_done
//  x_we           out  1  x register-file write enable
//  x_addr         out  4  x register-file write address
//  x_rd_addr      out  4  x register-file read address, 1-cycle read latency
//  out_valid      out  1  x_out (datapath side) valid
//  iter           out  8  completed sweeps
//  busy           out  1  high in every state except LOAD
// BEHAVIOUR
//  - Reset values: state=LOAD, all counters 0, every output 0.
//  - An active reset mid-operation aborts immediately. After reset, buffer contents are don't-care.
//  - LOAD
//    - b_we=in_en, b_addr=ld_cnt, both combinational.
//    - ld_cnt increments on each in_en; in_en gaps stall the count.
//    - The 16th write (ld_cnt=15) moves to ISSUE with row=0 and iter=0.
//  - ISSUE: dp_start=1 for exactly one cycle with dp_row=row and the mask valid; next state WAIT.
//  - WAIT
//    - Holds until dp_done. dp_done in any other state is ignored.
//    - On dp_done: x_we=1 and x_addr=row in that cycle. This is the Gauss-Seidel in-place write:
//      the next row sees the new value.
//    - row<15: row+1, then ISSUE.
//    - row=15 (end of sweep): iter+1. If iter+1==ITER_MAX go to OUT, else row=0 and ISSUE.
//  - Throughput: minimum 2 cycles per row (ISSUE + WAIT with dp_done in the first WAIT cycle).
//  - Mask: bit k is set only if the neighbour index lies in 0..15.
//    Row 0 -> 6'b111000; row 15 -> 6'b000111; rows 3..12 -> 6'b111111.
//  - OUT
//    - x_rd_addr=rd_cnt, incrementing 0..15 every cycle.
//    - out_valid is a registered copy of (state==OUT). It is high for exactly 16 consecutive
//      cycles, starting one cycle after OUT entry.
//    - After rd_cnt=15: go to LOAD with counters cleared; out_valid drops one cycle later.
//  - in_en outside LOAD is ignored: no b_we, no state change.
//  - iter saturates at ITER_MAX and is held until the next LOAD completes.
// CONFIGURATION
//  - GSIM_CONV_EN defined:
//    - A per-sweep flag all_small is ANDed with dp_small on every dp_done and set to 1 at sweep start.
//    - At end of sweep, all_small=1 goes to OUT early, even if iter+1<ITER_MAX.
//    - iter reports the sweeps actually run.
//  - GSIM_CONV_EN undefined: dp_small is unused and exactly ITER_MAX sweeps always run.
// STRUCTURE
//  - gsim_pkg: N_DIM, state enum {LOAD,ISSUE,WAIT,OUT}, coefficient constants (20,-13,6,-1),
//    mask width 6.
//  - Sub-module gsim_nbr_mask: purely combinational, row[3:0] -> dp_nbr_mask[5:0].
//  - Everything else (FSM plus ld/row/rd/iter counters) lives in gsim_sched.
// TESTING
//  1. 16 back-to-back in_en after reset release -> b_addr 0..15 with b_we high for 16 cycles,
//     busy rises the next cycle, dp_start follows with dp_row=0 and mask 6'b111000.
//  2. in_en pattern 1,1,0,0,1... (16 ones) -> b_addr contiguous 0..15, no skipped or duplicated addresses.
//  3. Datapath model replies dp_done 1 cycle after dp_start, ITER_MAX=4 -> 64 dp_start pulses,
//     64 x_we pulses, rows cycling 0..15, iter=4, then 16 out_valid cycles with x_rd_addr 0..15.
//  4. dp_done delayed 5 cycles and a spurious dp_done during ISSUE -> no extra x_we,
//     row advances only on the legal pulse.
//  5. reset asserted in WAIT at row 7 -> all outputs 0 asynchronously; after release a fresh
//     16-element load works.
//  6. GSIM_CONV_EN on, dp_small=1 from sweep 3 -> OUT after iter=3; with the macro off,
//     ITER_MAX sweeps run.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared types and constants for the 16-unknown Gauss-Seidel sequencer.
package gsim_pkg;

  localparam int N_DIM  = 16;
  localparam int ROW_W  = $clog2(N_DIM);
  localparam int MASK_W = 6;

  localparam int signed C_DIAG = 20;
  localparam int signed C_OFF1 = -13;
  localparam int signed C_OFF2 = 6;
  localparam int signed C_OFF3 = -1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;

endpackage

// File: rtl/gsim_nbr_mask.sv
// In-range neighbour mask {i+3,i+2,i+1,i-1,i-2,i-3} for a banded row.
module gsim_nbr_mask
  import gsim_pkg::*;
(
  input  logic [ROW_W-1:0]  row_i,
  output logic [MASK_W-1:0] mask_o
);

  always_comb begin
    mask_o[5] = (row_i <= 4'd12);
    mask_o[4] = (row_i <= 4'd13);
    mask_o[3] = (row_i <= 4'd14);
    mask_o[2] = (row_i >= 4'd1);
    mask_o[1] = (row_i >= 4'd2);
    mask_o[0] = (row_i >= 4'd3);
  end

endmodule

// File: rtl/gsim_sched.sv
// Gauss-Seidel sweep sequencer: b load, row issue/wait, x readout.
// Optional early exit on convergence with `define GSIM_CONV_EN.
module gsim_sched
  import gsim_pkg::*;
#(
  parameter int ITER_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  output logic              b_we,
  output logic [ROW_W-1:0]  b_addr,
  output logic              dp_start,
  output logic [ROW_W-1:0]  dp_row,
  output logic [MASK_W-1:0] dp_nbr_mask,
  input  logic              dp_done,
  input  logic              dp_small,
  output logic              x_we,
  output logic [ROW_W-1:0]  x_addr,
  output logic [ROW_W-1:0]  x_rd_addr,
  output logic              out_valid,
  output logic [7:0]        iter,
  output logic              busy
);

  localparam logic [ROW_W-1:0] LAST = ROW_W'(N_DIM - 1);

  state_e           state_q;
  logic [ROW_W-1:0] ld_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] rd_q;
  logic [7:0]       iter_q;
  logic             ov_q;

  logic             load_done;
  logic             row_done;
  logic             last_row;
  logic [7:0]       iter_d;
  logic             conv_hit;
  logic             stop;
  logic [MASK_W-1:0] mask;

  assign load_done = (state_q == ST_LOAD) && in_en && (ld_q == LAST);
  assign row_done  = (state_q == ST_WAIT) && dp_done;
  assign last_row  = (row_q == LAST);
  assign iter_d    = iter_q + 8'd1;
  assign stop      = (iter_d == 8'(ITER_MAX)) || conv_hit;

`ifdef GSIM_CONV_EN
  logic all_small_q;
  logic sweep_begin;

  assign sweep_begin = load_done || (row_done && last_row && !stop);
  assign conv_hit    = all_small_q && dp_small;

  // Cleared by any large row update; re-armed at each sweep start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      all_small_q <= 1'b0;
    end else if (sweep_begin) begin
      all_small_q <= 1'b1;
    end else if (row_done) begin
      all_small_q <= all_small_q && dp_small;
    end
  end
`else
  logic unused_small;
  assign unused_small = dp_small;
  assign conv_hit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      ld_q    <= '0;
      row_q   <= '0;
      rd_q    <= '0;
      iter_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= (state_q == ST_OUT);
      unique case (state_q)
        ST_LOAD: begin
          if (in_en) begin
            ld_q <= ld_q + 1'b1;
            if (ld_q == LAST) begin
              state_q <= ST_ISSUE;
              row_q   <= '0;
              iter_q  <= '0;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dp_done) begin
            if (!last_row) begin
              row_q   <= row_q + 1'b1;
              state_q <= ST_ISSUE;
            end else begin
              iter_q <= iter_d;
              row_q  <= '0;
              if (stop) begin
                state_q <= ST_OUT;
                rd_q    <= '0;
              end else begin
                state_q <= ST_ISSUE;
              end
            end
          end
        end
        ST_OUT: begin
          rd_q <= rd_q + 1'b1;
          if (rd_q == LAST) begin
            state_q <= ST_LOAD;
            ld_q    <= '0;
            row_q   <= '0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  gsim_nbr_mask u_mask (
    .row_i  (row_q),
    .mask_o (mask)
  );

  assign b_we        = (state_q == ST_LOAD) && in_en;
  assign b_addr      = ld_q;
  assign dp_start    = (state_q == ST_ISSUE);
  assign dp_row      = row_q;
  assign dp_nbr_mask = dp_start ? mask : '0;
  assign x_we        = row_done;
  assign x_addr      = row_q;
  assign x_rd_addr   = rd_q;
  assign out_valid   = ov_q;
  assign iter        = iter_q;
  assign busy        = (state_q != ST_LOAD);

endmodule

// File: tb/tb_gsim_sched.sv
// Directed bench for gsim_sched with ITER_MAX=4.
module tb_gsim_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_en = 1'b0;
  logic       dp_done = 1'b0;
  logic       dp_small = 1'b0;
  logic       b_we;
  logic [3:0] b_addr;
  logic       dp_start;
  logic [3:0] dp_row;
  logic [5:0] dp_nbr_mask;
  logic       x_we;
  logic [3:0] x_addr;
  logic [3:0] x_rd_addr;
  logic       out_valid;
  logic [7:0] iter;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gsim_sched #(.ITER_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_en       (in_en),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .dp_start    (dp_start),
    .dp_row      (dp_row),
    .dp_nbr_mask (dp_nbr_mask),
    .dp_done     (dp_done),
    .dp_small    (dp_small),
    .x_we        (x_we),
    .x_addr      (x_addr),
    .x_rd_addr   (x_rd_addr),
    .out_valid   (out_valid),
    .iter        (iter),
    .busy        (busy)
  );

  function automatic logic [5:0] exp_mask(input int r);
    exp_mask = {r + 3 <= 15, r + 2 <= 15, r + 1 <= 15,
                r - 1 >= 0, r - 2 >= 0, r - 3 >= 0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_en = 0; dp_done = 0; dp_small = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic do_load();
    in_en = 1;
    repeat (16) cyc();
    in_en = 0;
  endtask

  task automatic run_dp(input int small_from,
                        output int starts, output int xwes,
                        output int ovs, output int row_err,
                        output int rd_err, output logic [5:0] m7,
                        output logic [5:0] m15, output logic tmo);
    logic pend;
    logic [3:0] prev_rd;
    starts = 0; xwes = 0; ovs = 0; row_err = 0; rd_err = 0;
    m7 = '0; m15 = '0; tmo = 1; pend = 0; prev_rd = '0;
    for (int c = 0; c < 2000; c++) begin
      dp_done  = pend;
      dp_small = (starts > 0) && ((starts - 1) / 16 >= small_from);
      #1;
      if (x_we) begin
        xwes++;
        if (int'(x_addr) != (starts - 1) % 16) row_err++;
      end
      if (dp_start) begin
        if (int'(dp_row) != starts % 16) row_err++;
        if (dp_nbr_mask != exp_mask(int'(dp_row))) row_err++;
        if (dp_row == 4'd7) m7 = dp_nbr_mask;
        if (dp_row == 4'd15) m15 = dp_nbr_mask;
        starts++;
      end
      if (out_valid) begin
        if (prev_rd != 4'(ovs)) rd_err++;
        ovs++;
      end else if (ovs > 0) begin
        tmo = 0;
        break;
      end
      pend = dp_start;
      prev_rd = x_rd_addr;
      cyc();
    end
    dp_done = 0;
    dp_small = 0;
  endtask

  task automatic test_reset();
    reset = 0; in_en = 0; dp_done = 0;
    #3;
    n_chk++;
    if ({b_we, b_addr, dp_start, dp_row, dp_nbr_mask, x_we, x_addr,
         x_rd_addr, out_valid, iter, busy} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b iter=%0d row=%0d", busy, iter, dp_row);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      in_en = 1;
      #1;
      n_chk++;
      if (b_we !== 1'b1 || b_addr !== 4'(i) || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_load[%0d]: we=%b addr=%0d busy=%b want 1 %0d 0",
                 i, b_we, b_addr, busy, i);
      end
      cyc();
    end
    in_en = 0;
    #1;
    n_chk++;
    if (busy !== 1'b1 || dp_start !== 1'b1 || dp_row !== 4'd0 ||
        dp_nbr_mask !== 6'b111000) begin
      n_bad++;
      $display("FAIL b2b_issue: busy=%b start=%b row=%0d mask=%b want 1 1 0 111000",
               busy, dp_start, dp_row, dp_nbr_mask);
    end
  endtask

  task automatic test_load_gaps();
    int cnt;
    logic [15:0] seen;
    apply_reset();
    cnt = 0; seen = '0;
    for (int i = 0; i < 64 && cnt < 16; i++) begin
      in_en = ((i % 4) < 2);
      #1;
      n_chk++;
      if (in_en) begin
        if (b_we !== 1'b1 || b_addr !== 4'(cnt)) begin
          n_bad++;
          $display("FAIL gap_load[%0d]: we=%b addr=%0d want 1 %0d", i, b_we, b_addr, cnt);
        end
        seen[b_addr] = 1'b1;
        cnt++;
      end else if (b_we !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_idle[%0d]: we=%b want 0", i, b_we);
      end
      cyc();
    end
    in_en = 0;
    #1;
    n_chk++;
    if (seen !== 16'hFFFF || dp_start !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_cover: seen=%h start=%b want ffff 1", seen, dp_start);
    end
  endtask

  task automatic test_sweeps();
    int s, w, o, re, rde;
    logic [5:0] m7, m15;
    logic tmo;
    apply_reset();
    do_load();
    run_dp(99, s, w, o, re, rde, m7, m15, tmo);
    n_chk++;
    if (tmo !== 1'b0 || s != 64 || w != 64) begin
      n_bad++;
      $display("FAIL sweep_counts: tmo=%b starts=%0d xwe=%0d want 0 64 64", tmo, s, w);
    end
    n_chk++;
    if (re != 0 || m7 !== 6'b111111 || m15 !== 6'b000111) begin
      n_bad++;
      $display("FAIL sweep_rows: errs=%0d m7=%b m15=%b want 0 111111 000111", re, m7, m15);
    end
    n_chk++;
    if (o != 16 || rde != 0) begin
      n_bad++;
      $display("FAIL sweep_out: valid=%0d rd_errs=%0d want 16 0", o, rde);
    end
    n_chk++;
    if (iter !== 8'd4 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_iter: iter=%0d busy=%b want 4 0", iter, busy);
    end
  endtask

  task automatic test_delayed_done();
    apply_reset();
    do_load();
    dp_done = 1;
    #1;
    n_chk++;
    if (dp_start !== 1'b1 || x_we !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_issue: start=%b xwe=%b want 1 0", dp_start, x_we);
    end
    cyc();
    dp_done = 0;
    in_en = 1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_chk++;
      if (x_we !== 1'b0 || dp_start !== 1'b0 || dp_row !== 4'd0 ||
          b_we !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL wait_hold[%0d]: xwe=%b start=%b row=%0d bwe=%b busy=%b",
                 i, x_we, dp_start, dp_row, b_we, busy);
      end
      cyc();
    end
    in_en = 0;
    dp_done = 1;
    #1;
    n_chk++;
    if (x_we !== 1'b1 || x_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL late_done: xwe=%b addr=%0d want 1 0", x_we, x_addr);
    end
    cyc();
    dp_done = 0;
    #1;
    n_chk++;
    if (dp_start !== 1'b1 || dp_row !== 4'd1 || dp_nbr_mask !== 6'b111100) begin
      n_bad++;
      $display("FAIL next_row: start=%b row=%0d mask=%b want 1 1 111100",
               dp_start, dp_row, dp_nbr_mask);
    end
  endtask

  task automatic test_reset_mid();
    logic pend, found;
    apply_reset();
    do_load();
    pend = 0; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      dp_done = pend;
      #1;
      found = dp_start && (dp_row == 4'd7);
      pend = dp_start;
      cyc();
    end
    dp_done = 0;
    #1;
    n_chk++;
    if (!found || busy !== 1'b1 || dp_row !== 4'd7) begin
      n_bad++;
      $display("FAIL reach_row7: found=%b busy=%b row=%0d", found, busy, dp_row);
    end
    reset = 0;
    #1;
    n_chk++;
    if ({b_we, b_addr, dp_start, dp_row, dp_nbr_mask, x_we, x_addr,
         x_rd_addr, out_valid, iter, busy} !== 35'd0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b row=%0d start=%b", busy, dp_row, dp_start);
    end
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < 16; i++) begin
      in_en = 1;
      #1;
      n_chk++;
      if (b_we !== 1'b1 || b_addr !== 4'(i)) begin
        n_bad++;
        $display("FAIL reload[%0d]: we=%b addr=%0d want 1 %0d", i, b_we, b_addr, i);
      end
      cyc();
    end
    in_en = 0;
    #1;
    n_chk++;
    if (dp_start !== 1'b1 || dp_row !== 4'd0 || iter !== 8'd0) begin
      n_bad++;
      $display("FAIL reload_issue: start=%b row=%0d iter=%0d", dp_start, dp_row, iter);
    end
  endtask

  task automatic test_conv();
    int s, w, o, re, rde;
    int exp_s;
    logic [7:0] exp_it;
    logic [5:0] m7, m15;
    logic tmo;
`ifdef GSIM_CONV_EN
    exp_s = 48; exp_it = 8'd3;
`else
    exp_s = 64; exp_it = 8'd4;
`endif
    apply_reset();
    do_load();
    run_dp(2, s, w, o, re, rde, m7, m15, tmo);
    n_chk++;
    if (tmo !== 1'b0 || s != exp_s || w != exp_s || iter !== exp_it || o != 16) begin
      n_bad++;
      $display("FAIL conv: tmo=%b starts=%0d xwe=%0d iter=%0d valid=%0d want %0d %0d",
               tmo, s, w, iter, o, exp_s, exp_it);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_gaps();
    test_sweeps();
    test_delayed_done();
    test_reset_mid();
    test_conv();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
